// File: rtl/one_hot_encoder_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_encoder_pipe_if
// Description : Upstream/downstream handshake bundle for one_hot_encoder_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
interface one_hot_encoder_pipe_if #(
    parameter int WIDTH = 16
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IDX_W-1:0] in_index;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_one_hot;
    logic [IDX_W-1:0] out_index;
    logic             err;

    modport master (
        output flush, in_valid, in_index, out_ready,
        input  in_ready, out_valid, out_one_hot, out_index, err
    );

    modport slave (
        input  flush, in_valid, in_index, out_ready,
        output in_ready, out_valid, out_one_hot, out_index, err
    );
endinterface
`default_nettype wire

// File: rtl/one_hot_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : one_hot_encoder_pipe
// Description : Binary index to one-hot encoder behind a two-slot skid buffer.
//               Optional macro ONE_HOT_RANGE_CHECK_EN flags out-of-range indices.
// Revision    : 1.0 - initial release
// ============================================================================
module one_hot_encoder_pipe #(
    parameter int WIDTH = 16
) (
    input  wire logic             clock,
    input  wire logic             reset_n,
    one_hot_encoder_pipe_if.slave bus
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             r_or_valid;
    logic [WIDTH-1:0] r_or_hot;
    logic [IDX_W-1:0] r_or_idx;
    logic             r_sk_valid;
    logic [WIDTH-1:0] r_sk_hot;
    logic [IDX_W-1:0] r_sk_idx;

    logic [WIDTH-1:0] w_one_hot;
    logic             w_in_fire;
    logic             w_out_fire;
    logic             w_load_or_new;
    logic             w_load_or_sk;
    logic             w_load_sk;

    // An index >= WIDTH matches no bit, leaving the vector all-zero.
    always_comb begin
        w_one_hot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_one_hot[i] = (bus.in_index == IDX_W'(i));
        end
    end

    assign w_in_fire     = bus.in_valid & ~r_sk_valid;
    assign w_out_fire    = r_or_valid & bus.out_ready;
    assign w_load_or_sk  = ~bus.flush & w_out_fire & r_sk_valid;
    assign w_load_or_new = ~bus.flush & w_in_fire & (~r_or_valid | w_out_fire);
    assign w_load_sk     = ~bus.flush & w_in_fire & r_or_valid & ~w_out_fire;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_or_valid <= 1'b0;
            r_or_hot   <= '0;
            r_or_idx   <= '0;
            r_sk_valid <= 1'b0;
            r_sk_hot   <= '0;
            r_sk_idx   <= '0;
        end else begin
            if (bus.flush) begin
                r_or_valid <= 1'b0;
                r_sk_valid <= 1'b0;
            end else begin
                if (w_load_or_sk || w_load_or_new) begin
                    r_or_valid <= 1'b1;
                end else if (w_out_fire) begin
                    r_or_valid <= 1'b0;
                end
                if (w_load_sk) begin
                    r_sk_valid <= 1'b1;
                end else if (w_load_or_sk) begin
                    r_sk_valid <= 1'b0;
                end
            end

            if (w_load_or_sk) begin
                r_or_hot <= r_sk_hot;
                r_or_idx <= r_sk_idx;
            end else if (w_load_or_new) begin
                r_or_hot <= w_one_hot;
                r_or_idx <= bus.in_index;
            end
            if (w_load_sk) begin
                r_sk_hot <= w_one_hot;
                r_sk_idx <= bus.in_index;
            end
        end
    end

`ifdef ONE_HOT_RANGE_CHECK_EN
    logic w_err;
    logic r_or_err;
    logic r_sk_err;

    assign w_err = ~|w_one_hot;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_or_err <= 1'b0;
            r_sk_err <= 1'b0;
        end else begin
            if (w_load_or_sk) begin
                r_or_err <= r_sk_err;
            end else if (w_load_or_new) begin
                r_or_err <= w_err;
            end
            if (w_load_sk) begin
                r_sk_err <= w_err;
            end
        end
    end

    assign bus.err = r_or_err;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.in_ready    = ~r_sk_valid;
    assign bus.out_valid   = r_or_valid;
    assign bus.out_one_hot = r_or_hot;
    assign bus.out_index   = r_or_idx;

endmodule
`default_nettype wire

// File: tb/tb_one_hot_encoder_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_one_hot_encoder_pipe
// Description : Self-checking bench: queue-based reference model plus directed cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_one_hot_encoder_pipe;
    logic clock = 1'b0;
    logic reset_n;
    int   vectors = 0;
    int   miscompares = 0;

    always #5 clock = ~clock;

    one_hot_encoder_pipe_if #(.WIDTH(16)) bus   ();
    one_hot_encoder_pipe_if #(.WIDTH(12)) bus12 ();

    one_hot_encoder_pipe #(.WIDTH(16)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    one_hot_encoder_pipe #(.WIDTH(12)) dut12 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus12.slave)
    );

    // Reference: the buffer is a FIFO of at most two accepted indices.
    int q[$];

`ifdef ONE_HOT_RANGE_CHECK_EN
    localparam bit RANGE_CHK = 1'b1;
`else
    localparam bit RANGE_CHK = 1'b0;
`endif

    function automatic logic [63:0] exp_hot(input int w, input int idx);
        return (idx < w) ? (64'd1 << idx) : 64'd0;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        check("out_valid", 64'(bus.out_valid), 64'(q.size() > 0));
        check("in_ready", 64'(bus.in_ready), 64'(q.size() < 2));
        if (q.size() > 0) begin
            check("out_one_hot", 64'(bus.out_one_hot), exp_hot(16, q[0]));
            check("out_index", 64'(bus.out_index), 64'(q[0]));
            check("err", 64'(bus.err), 64'd0);
        end
    endtask

    // Called at a falling edge: check, drive, advance one clock, update model.
    task automatic step(input logic fl, input logic iv, input int idx, input logic ordy);
        bit in_fire;
        bit out_fire;
        check_model();
        bus.flush     = fl;
        bus.in_valid  = iv;
        bus.in_index  = 4'(idx);
        bus.out_ready = ordy;
        in_fire  = iv && (q.size() < 2);
        out_fire = ordy && (q.size() > 0);
        @(posedge clock);
        if (fl) begin
            q.delete();
        end else begin
            if (out_fire) void'(q.pop_front());
            if (in_fire) q.push_back(idx);
        end
        @(negedge clock);
    endtask

    initial begin
        reset_n        = 1'b0;
        bus.flush      = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_index   = '0;
        bus.out_ready  = 1'b0;
        bus12.flush    = 1'b0;
        bus12.in_valid = 1'b0;
        bus12.in_index = '0;
        bus12.out_ready = 1'b1;

        repeat (2) @(negedge clock);
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_in_ready", 64'(bus.in_ready), 64'd1);
        check("rst_one_hot", 64'(bus.out_one_hot), 64'd0);
        check("rst_index", 64'(bus.out_index), 64'd0);
        check("rst_err", 64'(bus.err), 64'd0);
        reset_n = 1'b1;

        // Single index, one cycle latency.
        step(1'b0, 1'b1, 5, 1'b1);
        check("idx5_hot", 64'(bus.out_one_hot), 64'h0020);
        step(1'b0, 1'b0, 0, 1'b1);

        // Stall: 3 into output slot, 9 into skid, third offer refused.
        step(1'b0, 1'b1, 3, 1'b0);
        step(1'b0, 1'b1, 9, 1'b0);
        check("stall_hot", 64'(bus.out_one_hot), 64'h0008);
        check("stall_in_ready", 64'(bus.in_ready), 64'd0);
        step(1'b0, 1'b1, 7, 1'b0);
        step(1'b0, 1'b0, 0, 1'b1);
        check("drain_hot", 64'(bus.out_one_hot), 64'h0200);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Back-to-back walking one.
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, i, 1'b1);
            check("walk_hot", 64'(bus.out_one_hot), 64'd1 << i);
        end
        step(1'b0, 1'b0, 0, 1'b1);

        // Flush with both slots full and an index on offer.
        step(1'b0, 1'b1, 2, 1'b0);
        step(1'b0, 1'b1, 4, 1'b0);
        step(1'b1, 1'b1, 6, 1'b0);
        check("flush_out_valid", 64'(bus.out_valid), 64'd0);
        check("flush_in_ready", 64'(bus.in_ready), 64'd1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step(1'b0 | ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
                 int'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0));
        end

        // Asynchronous reset between edges with both slots full.
        step(1'b0, 1'b1, 10, 1'b0);
        step(1'b0, 1'b1, 11, 1'b0);
        step(1'b0, 1'b1, 12, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        q.delete();
        check("arst_out_valid", 64'(bus.out_valid), 64'd0);
        check("arst_in_ready", 64'(bus.in_ready), 64'd1);
        check("arst_one_hot", 64'(bus.out_one_hot), 64'd0);
        check("arst_index", 64'(bus.out_index), 64'd0);
        check("arst_err", 64'(bus.err), 64'd0);
        @(negedge clock);
        reset_n = 1'b1;
        step(1'b0, 1'b1, 14, 1'b1);
        check("post_rst_hot", 64'(bus.out_one_hot), 64'h4000);
        step(1'b0, 1'b0, 0, 1'b1);
        step(1'b0, 1'b0, 0, 1'b1);

        // Non-power-of-two width: out-of-range and top legal index.
        bus12.in_valid = 1'b1;
        bus12.in_index = 4'd13;
        @(negedge clock);
        bus12.in_valid = 1'b1;
        bus12.in_index = 4'd11;
        check("w12_oor_valid", 64'(bus12.out_valid), 64'd1);
        check("w12_oor_hot", 64'(bus12.out_one_hot), 64'h000);
        check("w12_oor_index", 64'(bus12.out_index), 64'd13);
        check("w12_oor_err", 64'(bus12.err), 64'(RANGE_CHK));
        @(negedge clock);
        bus12.in_valid = 1'b0;
        check("w12_top_hot", 64'(bus12.out_one_hot), 64'h800);
        check("w12_top_err", 64'(bus12.err), 64'd0);
        @(negedge clock);
        check("w12_idle_valid", 64'(bus12.out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/one_hot_encoder_pipe.md
ONE_HOT_ENCODER_PIPE -- requirements
Module: one_hot_encoder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the one-hot vector width; legal range 2..64, power of two not required.
REQ-002 SHALL have derived localparam IDX_W = ceil(log2(WIDTH)), giving the binary index width.
REQ-003 SHALL have port clock, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port flush, input, 1 bit: synchronous clear of all buffered entries.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream index valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept an index this cycle.
REQ-008 SHALL have port in_index, input, IDX_W bits: binary way/line index to encode.
REQ-009 SHALL have port out_valid, output, 1 bit: out_one_hot/out_index hold a valid entry.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the current entry.
REQ-011 SHALL have port out_one_hot, output, WIDTH bits: decoded one-hot vector, bit in_index set.
REQ-012 SHALL have port out_index, output, IDX_W bits: the binary index carried alongside the vector.
REQ-013 SHALL have port err, output, 1 bit: current output entry had an out-of-range index (see Configuration).

Function
REQ-014 SHALL hold two storage slots: output register OR (drives outputs) and skid register SK; each slot has a valid bit.
REQ-015 SHALL drive in_ready = !SK.valid, with no combinational path from out_ready.
REQ-016 SHALL count a transfer in when in_valid && in_ready, and a transfer out when out_valid && out_ready.
REQ-017 SHALL, on transfer in when OR is empty or OR is being transferred out with SK empty, load OR; latency in->out is exactly 1 cycle.
REQ-018 SHALL, on transfer in while OR is valid and not transferring out, load SK.
REQ-019 SHALL, on transfer out with SK valid, move SK into OR and clear SK in the same edge.
REQ-020 SHALL, on simultaneous transfer in and transfer out with SK valid, be impossible because in_ready=0; when SK is empty, the new entry loads OR directly.
REQ-021 SHALL sustain one transfer per cycle when out_ready is held high; entries SHALL leave in acceptance order, with no loss or duplication.
REQ-022 SHALL set out_one_hot[in_index]=1 and all other bits 0 for in_index < WIDTH, computed before registering.
REQ-023 SHALL set out_one_hot to all-zero for in_index >= WIDTH (only possible when WIDTH is not a power of two).
REQ-024 SHALL drive out_valid = OR.valid; out_one_hot, out_index and err SHALL be stable while out_valid && !out_ready.
REQ-025 SHALL, on flush, clear OR.valid and SK.valid at the next edge, ignoring any same-cycle transfer in; in_ready SHALL be 1 the cycle after.

Reset
REQ-026 SHALL, while reset_n=0, asynchronously force OR.valid=0, SK.valid=0, out_valid=0, in_ready=1, out_one_hot=0, out_index=0, err=0.
REQ-027 SHALL, on reset asserted mid-transfer, discard all buffered entries; the first accepted index after release appears on the outputs one cycle later.

Configuration
REQ-028 SHALL, with macro ONE_HOT_RANGE_CHECK_EN defined, register err=1 with any entry whose in_index >= WIDTH, carried through SK/OR with its entry.
REQ-029 SHALL, without ONE_HOT_RANGE_CHECK_EN, tie err to 0 and add no range-check logic; out_one_hot is still all-zero per REQ-023.

Verification
REQ-030 SHALL cover: WIDTH=16, in_index=5 accepted with out_ready=1 -> next cycle out_valid=1, out_one_hot=0x0020, out_index=5.
REQ-031 SHALL cover: out_ready=0, indices 3 then 9 offered -> OR=0x0008, SK holds 9, in_ready=0; out_ready=1 -> 0x0008 then 0x0200 on consecutive cycles.
REQ-032 SHALL cover: out_ready=1 continuously, indices 0..15 offered back-to-back -> 16 outputs on 16 consecutive cycles, walking one from 0x0001 to 0x8000.
REQ-033 SHALL cover: WIDTH=12, in_index=13 with ONE_HOT_RANGE_CHECK_EN -> out_one_hot=0x000, err=1; without the macro -> err=0.
REQ-034 SHALL cover: both slots full, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the offered index is dropped.
REQ-035 SHALL cover: reset_n pulsed low between clock edges with both slots full -> outputs zero immediately, and in_ready=1.
